ldst_mem_rsp: RTL



---
 rtl/ldst_mem_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 54 +++++
 rtl/ldst_mem_rsp.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ldst_mem_pkg.sv
// Shared types and helpers for the load/store data memory responder.
package ldst_mem_pkg;

  localparam int unsigned RV_XLEN    = 32;
  localparam int unsigned RV_AW      = 32;
  localparam int unsigned WORD_SHIFT = 2;  // byte address -> word index
  localparam int unsigned BYTE_SHIFT = 3;  // byte lane -> bit offset

  typedef struct packed {
    logic [RV_XLEN-1:0] data;
    logic               ok;
  } ldst_mem_rsp_t;

  typedef struct packed {
    logic             err;
    logic [RV_AW-1:0] idx;
  } ldst_chk_t;

  // Underflow of addr - base is caught by the extra top bit of the difference.
  function automatic ldst_chk_t ldst_addr_chk(input logic [RV_AW-1:0] addr,
                                              input logic [RV_AW-1:0] base,
                                              input int unsigned      depth);
    logic [RV_AW:0] off;
    ldst_chk_t      r;
    off   = {1'b0, addr} - {1'b0, base};
    r.idx = off[RV_AW-1:0] >> WORD_SHIFT;
    r.err = (addr[WORD_SHIFT-1:0] != '0) || off[RV_AW] || (r.idx >= RV_AW'(depth));
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; pop and push at full in one cycle is allowed.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] cnt_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ldst_mem_rsp.sv
// Tightly-coupled data SRAM answering LSU load/store requests in order.
// Optional LDST_MEM_WAIT_EN adds WAIT_CYCLES of access latency per request.
module ldst_mem_rsp
  import ldst_mem_pkg::*;
#(
  parameter int unsigned      DEPTH_WORDS    = 4096,
  parameter logic [RV_AW-1:0] BASE_ADDR      = 32'h8000_0000,
  parameter int unsigned      RSP_FIFO_DEPTH = 2,
  parameter int unsigned      WAIT_CYCLES    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_vld_i,
  output logic                 req_rdy_o,
  input  logic [RV_AW-1:0]     req_addr_i,
  input  logic                 req_st_i,
  input  logic [RV_XLEN-1:0]   req_data_i,
  input  logic [RV_XLEN/8-1:0] req_strobe_i,
  output logic                 rsp_vld_o,
  input  logic                 rsp_rdy_i,
  output logic [RV_XLEN-1:0]   rsp_data_o,
  output logic                 rsp_ok_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CW    = $clog2(RSP_FIFO_DEPTH + 1);
  localparam int unsigned RSP_W = $bits(ldst_mem_rsp_t);

  logic [RV_XLEN-1:0] mem_q [DEPTH_WORDS];
  logic [RV_XLEN-1:0] rdata_q;
  logic               pend_vld_q, pend_ok_q, pend_ld_q;
  logic               s1_vld, issue_ok, accept, wr_en, rd_en;
  logic [IDX_W-1:0]   idx;
  ldst_chk_t          chk;
  ldst_mem_rsp_t      s1_pkt, rsp_pkt;
  logic [RSP_W-1:0]   fifo_head;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_cnt;
  logic [CW:0]        credit_used;
  logic [RV_AW-1:0]   unused_idx_bits;

  assign chk             = ldst_addr_chk(req_addr_i, BASE_ADDR, DEPTH_WORDS);
  assign idx             = chk.idx[IDX_W-1:0];
  assign unused_idx_bits = chk.idx;

  // Credit counts the s1 slot so rsp_rdy_i never reaches req_rdy_o combinationally.
  assign credit_used = {1'b0, fifo_cnt} + {{CW{1'b0}}, pend_vld_q};
  assign req_rdy_o   = !rst && issue_ok && (credit_used < (CW+1)'(RSP_FIFO_DEPTH));
  assign accept      = req_vld_i && req_rdy_o;
  assign wr_en       = accept && req_st_i && !chk.err;
  assign rd_en       = accept && !req_st_i && !chk.err;

  // NOTE: SRAM contents are deliberately not reset; only control state is.
  always_ff @(posedge clk) begin
    for (int b = 0; b < RV_XLEN / 8; b++) begin
      if (wr_en && req_strobe_i[b]) mem_q[idx][(b << BYTE_SHIFT) +: 8] <= req_data_i[(b << BYTE_SHIFT) +: 8];
    end
    if (rd_en) rdata_q <= mem_q[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld_q <= 1'b0;
      pend_ok_q  <= 1'b0;
      pend_ld_q  <= 1'b0;
    end else if (accept) begin
      pend_vld_q <= 1'b1;
      pend_ok_q  <= !chk.err;
      pend_ld_q  <= !req_st_i && !chk.err;
    end else if (s1_vld) begin
      pend_vld_q <= 1'b0;
    end
  end

`ifdef LDST_MEM_WAIT_EN
  localparam int unsigned WW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [WW-1:0] wait_q;

  always_ff @(posedge clk) begin
    if (rst)                 wait_q <= '0;
    else if (accept)         wait_q <= WW'(WAIT_CYCLES);
    else if (wait_q != '0)   wait_q <= wait_q - 1'b1;
  end

  assign s1_vld   = pend_vld_q && (wait_q == '0);
  assign issue_ok = !pend_vld_q && (wait_q == '0);
`else
  localparam int unsigned unused_wait_cycles = WAIT_CYCLES;
  assign s1_vld   = pend_vld_q;
  assign issue_ok = 1'b1;
`endif

  assign s1_pkt = '{data: (s1_vld && pend_ld_q) ? rdata_q : '0, ok: s1_vld && pend_ok_q};

  // s1 bypasses straight to the port only when nothing older is buffered.
  assign fifo_pop  = !fifo_empty && rsp_rdy_i;
  assign fifo_push = s1_vld && !(fifo_empty && rsp_rdy_i);

  sync_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (s1_pkt),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .cnt_o   (fifo_cnt)
  );

  always_comb begin
    // NOTE: default first so every path assigns rsp_pkt and no latch is inferred.
    rsp_pkt = '0;
    if (!fifo_empty) rsp_pkt = ldst_mem_rsp_t'(fifo_head);
    else if (s1_vld) rsp_pkt = s1_pkt;
  end

  assign rsp_vld_o  = !fifo_empty || s1_vld;
  assign rsp_data_o = rsp_pkt.data;
  assign rsp_ok_o   = rsp_pkt.ok;

  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;

endmodule
